glb_proc_req_ctrl: RTL

//  West-edge processor request controller; feeds packet_w2e into the west port of GLB tile 0.

---
 rtl/glb_proc_req_ctrl_pkg.sv | 40 ++++
 rtl/glb_proc_req_ctrl_if.sv | 28 ++
 rtl/glb_proc_rd_tracker.sv | 79 +++++++
 rtl/glb_proc_req_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/glb_proc_req_ctrl_pkg.sv
// Shared types and defaults for the GLB west-edge processor request controller.
// Packet layout mirrors the GLB tile packet chain (wr / rdrq / rdrs sections).
package glb_proc_req_ctrl_pkg;

  localparam int GLB_ADDR_WIDTH      = 22;
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int BANK_STRB_WIDTH     = BANK_DATA_WIDTH / 8;
  localparam int GLB_PROC_MAX_OUTST  = 4;
  localparam int GLB_PROC_RD_TIMEOUT = 256;

  typedef struct packed {
    logic                       wr_en;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;

  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef struct packed {
    logic [BANK_DATA_WIDTH-1:0] rd_data;
    logic                       rd_data_valid;
  } rdrs_packet_t;

  typedef struct packed {
    wr_packet_t   wr;
    rdrq_packet_t rdrq;
    rdrs_packet_t rdrs;
  } packet_t;

  // Read tracker state: IDLE means nothing in flight.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/glb_proc_req_ctrl_if.sv
// Processor-side request/response bundle. master = processor, slave = controller.
interface glb_proc_req_ctrl_if
  import glb_proc_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = GLB_ADDR_WIDTH,
  parameter int DATA_W = BANK_DATA_WIDTH
);
  logic                  proc_wr_en;
  logic [DATA_W/8-1:0]   proc_wr_strb;
  logic [ADDR_W-1:0]     proc_wr_addr;
  logic [DATA_W-1:0]     proc_wr_data;
  logic                  proc_rd_en;
  logic [ADDR_W-1:0]     proc_rd_addr;
  logic                  proc_rd_ready;
  logic [DATA_W-1:0]     proc_rd_data;
  logic                  proc_rd_data_valid;
  logic                  proc_rd_err;

  modport master (
    output proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data, proc_rd_en, proc_rd_addr,
    input  proc_rd_ready, proc_rd_data, proc_rd_data_valid, proc_rd_err
  );

  modport slave (
    input  proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data, proc_rd_en, proc_rd_addr,
    output proc_rd_ready, proc_rd_data, proc_rd_data_valid, proc_rd_err
  );
endinterface

// File: rtl/glb_proc_rd_tracker.sv
// Outstanding-read credit counter. With GLB_PROC_RD_TIMEOUT_EN defined, adds an
// IDLE/WAIT FSM whose timer forces completion of a read that never gets a response.
module glb_proc_rd_tracker
  import glb_proc_req_ctrl_pkg::*;
#(
  parameter int MAX_OUTST  = GLB_PROC_MAX_OUTST,
  parameter int RD_TIMEOUT = GLB_PROC_RD_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd_req,      // processor read request (before credit gating)
  input  logic rsp_valid,   // raw response strobe from the e2w chain
  output logic rd_ready,
  output logic rd_accept,
  output logic rsp_ok,      // response that retires an outstanding read
  output logic rsp_spur,    // response with nothing outstanding
  output logic rd_timeout   // forced completion this cycle
);
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done;

  assign rd_ready  = cnt_q < CW'(MAX_OUTST);
  assign rd_accept = rd_req & rd_ready;
  assign rsp_ok    = rsp_valid & (cnt_q != '0);
  assign rsp_spur  = rsp_valid & (cnt_q == '0);
  assign done      = rsp_ok | rd_timeout;

  // Credit count: accept and completion in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({rd_accept, done})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

`ifdef GLB_PROC_RD_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT);

  rd_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  // A response in the expiry cycle wins, so the timeout needs a quiet response port.
  assign rd_timeout = (state_q == RD_WAIT) & ~rsp_valid & (timer_q == TW'(RD_TIMEOUT - 1));

  // Timer restarts on entry to WAIT, on any response and on a forced completion.
  always_comb begin
    timer_d = timer_q;
    if (state_q == RD_IDLE || rsp_valid || rd_timeout) timer_d = '0;
    else                                               timer_d = timer_q + TW'(1);
    state_d = (cnt_d == '0) ? RD_IDLE : RD_WAIT;
  end

  // FSM state and timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RD_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end
`else
  logic [31:0] unused_rd_timeout;
  assign unused_rd_timeout = 32'(RD_TIMEOUT);
  assign rd_timeout        = 1'b0;
`endif

endmodule

// File: rtl/glb_proc_req_ctrl.sv
// West-edge processor request controller for GLB tile 0.
// Registers processor writes/reads into packet_w2e_esto, caps outstanding reads
// and returns in-order read responses from packet_e2w_wsti.rdrs.
// Optional feature: define GLB_PROC_RD_TIMEOUT_EN for forced read completion.
module glb_proc_req_ctrl
  import glb_proc_req_ctrl_pkg::*;
#(
  parameter int ADDR_W     = GLB_ADDR_WIDTH,
  parameter int DATA_W     = BANK_DATA_WIDTH,
  parameter int MAX_OUTST  = GLB_PROC_MAX_OUTST,
  parameter int RD_TIMEOUT = GLB_PROC_RD_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  glb_proc_req_ctrl_if.slave        proc_if,
  output packet_t                   packet_w2e_esto,
  input  packet_t                   packet_e2w_wsti
);
  wr_packet_t          wr_q, wr_d;
  rdrq_packet_t        rdrq_q, rdrq_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_vld_q, rd_vld_d;
  logic                rd_err_q, rd_err_d;

  logic rd_ready, rd_accept, rsp_ok, rsp_spur, rd_timeout;

  glb_proc_rd_tracker #(
    .MAX_OUTST  (MAX_OUTST),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_req     (proc_if.proc_rd_en),
    .rsp_valid  (packet_e2w_wsti.rdrs.rd_data_valid),
    .rd_ready   (rd_ready),
    .rd_accept  (rd_accept),
    .rsp_ok     (rsp_ok),
    .rsp_spur   (rsp_spur),
    .rd_timeout (rd_timeout)
  );

  // Only the rdrs section of the incoming chain packet is ours.
  logic unused_wsti;
  assign unused_wsti = ^{packet_e2w_wsti.wr, packet_e2w_wsti.rdrq};

  // Next packet contents and response outputs; idle fields are zeroed, not held.
  always_comb begin
    wr_d = '0;
    if (proc_if.proc_wr_en) begin
      wr_d.wr_en   = 1'b1;
      wr_d.wr_strb = proc_if.proc_wr_strb;
      wr_d.wr_addr = proc_if.proc_wr_addr;
      wr_d.wr_data = proc_if.proc_wr_data;
    end
    rdrq_d = '0;
    if (rd_accept) begin
      rdrq_d.rd_en   = 1'b1;
      rdrq_d.rd_addr = proc_if.proc_rd_addr;
    end
    rd_data_d = rd_data_q;
    if (rsp_ok)          rd_data_d = packet_e2w_wsti.rdrs.rd_data;
    else if (rd_timeout) rd_data_d = '0;
    rd_vld_d = rsp_ok | rd_timeout;
    rd_err_d = rsp_spur | rd_timeout;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q      <= '0;
      rdrq_q    <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rdrq_q    <= rdrq_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign packet_w2e_esto.wr   = wr_q;
  assign packet_w2e_esto.rdrq = rdrq_q;
  assign packet_w2e_esto.rdrs = '0;

  assign proc_if.proc_rd_ready      = rd_ready;
  assign proc_if.proc_rd_data       = rd_data_q;
  assign proc_if.proc_rd_data_valid = rd_vld_q;
  assign proc_if.proc_rd_err        = rd_err_q;

endmodule
